// File: rtl/axi_tgen_pkg.sv
// Shared types and helpers for the AXI traffic generator: state encoding,
// AXI burst codes, bus structs and the AXSIZE helper.
package axi_tgen_pkg;

   // Widths of the AXI bus structs; the generator parameters default to these.
   localparam int AXI_ID_W_W = 4;
   localparam int AXI_ID_R_W = 4;
   localparam int AXI_ADDR_W = 4;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   // AXI burst encodings (passed through untouched, listed for callers).
   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_DONE
   } tgen_state_e;

   // Master-driven AXI signals.
   typedef struct packed {
      logic [AXI_ID_W_W-1:0] awid;
      logic [AXI_ADDR_W-1:0] awaddr;
      logic [7:0]            awlen;
      logic [2:0]            awsize;
      logic [1:0]            awburst;
      logic                  awvalid;
      logic [AXI_DATA_W-1:0] wdata;
      logic [AXI_STRB_W-1:0] wstrb;
      logic                  wlast;
      logic                  wvalid;
      logic                  bready;
      logic [AXI_ID_R_W-1:0] arid;
      logic [AXI_ADDR_W-1:0] araddr;
      logic [7:0]            arlen;
      logic [2:0]            arsize;
      logic [1:0]            arburst;
      logic                  arvalid;
      logic                  rready;
   } axi_mosi_t;

   // Slave-driven AXI signals.
   typedef struct packed {
      logic                  awready;
      logic                  wready;
      logic [AXI_ID_W_W-1:0] bid;
      logic [1:0]            bresp;
      logic                  bvalid;
      logic                  arready;
      logic [AXI_ID_R_W-1:0] rid;
      logic [AXI_DATA_W-1:0] rdata;
      logic [1:0]            rresp;
      logic                  rlast;
      logic                  rvalid;
   } axi_miso_t;

   // AXSIZE code for a full-width beat: log2 of bytes per beat.
   function automatic logic [2:0] size_from_width(input int data_w, input int byte_w);
      return 3'($clog2(data_w / byte_w));
   endfunction

endpackage

// File: rtl/axi_tgen_pattern.sv
// Deterministic beat pattern: data is seed+beat (wrapping), last flags the
// beat that should carry WLAST/RLAST. Shared by the write and read paths.
module axi_tgen_pattern #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] seed_i,
   input  logic [7:0]        beat_i,
   input  logic [7:0]        len_i,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o
);

   assign data_o = seed_i + DATA_W'(beat_i);
   assign last_o = (beat_i == len_i);

endmodule

// File: rtl/axi_traffic_gen.sv
// AXI traffic generator: one write burst of seed+beat data, wait for the
// write response, read the same range back and compare each beat.
// Build option: define AXI_TGEN_CHECK_EN to compile in the read-data
// comparator, err_count_o and the RLAST position checks; without it read
// data is drained unchecked and error_o reports watchdog aborts only.
module axi_traffic_gen
   import axi_tgen_pkg::*;
#(
   parameter int ID_W_WIDTH     = AXI_ID_W_W,
   parameter int ID_R_WIDTH     = AXI_ID_R_W,
   parameter int ADDR_WIDTH     = AXI_ADDR_W,
   parameter int AXI_DATA_WIDTH = AXI_DATA_W,
   parameter int BYTE_WIDTH     = 8,
   parameter int TXN_ID         = 0,
   parameter int TIMEOUT        = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      start_i,
   input  logic [ADDR_WIDTH-1:0]     base_addr_i,
   input  logic [7:0]                len_i,
   input  logic [1:0]                burst_i,
   input  logic [AXI_DATA_WIDTH-1:0] seed_i,
   output axi_mosi_t                 out_mosi_o,
   input  axi_miso_t                 out_miso_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [15:0]               err_count_o
);

   localparam int          WDOG_W   = $clog2(TIMEOUT + 1);
   localparam logic [2:0]  AXI_SIZE = size_from_width(AXI_DATA_WIDTH, BYTE_WIDTH);

   tgen_state_e               r_state;
   tgen_state_e               w_state_nxt;
   logic [ADDR_WIDTH-1:0]     r_base;
   logic [7:0]                r_len;
   logic [1:0]                r_burst;
   logic [AXI_DATA_WIDTH-1:0] r_seed;
   logic [7:0]                r_beat;
   logic [WDOG_W-1:0]         r_wdog;
   logic                      r_error;

   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic                      w_last;
   logic                      w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_hs;
   logic                      w_wait_state;
   logic                      w_timeout;
   logic                      w_unused;

   axi_tgen_pattern #(.DATA_W(AXI_DATA_WIDTH)) u_pattern (
      .seed_i (r_seed),
      .beat_i (r_beat),
      .len_i  (r_len),
      .data_o (w_data),
      .last_o (w_last)
   );

   // READY/VALID are decoded from state, so a handshake is state AND the peer's flag.
   assign w_aw_hs = (r_state == ST_AW) && out_miso_i.awready;
   assign w_w_hs  = (r_state == ST_W)  && out_miso_i.wready;
   assign w_b_hs  = (r_state == ST_B)  && out_miso_i.bvalid;
   assign w_ar_hs = (r_state == ST_AR) && out_miso_i.arready;
   assign w_r_hs  = (r_state == ST_R)  && out_miso_i.rvalid;
   assign w_hs    = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

   assign w_wait_state = (r_state == ST_AW) || (r_state == ST_W) || (r_state == ST_B) ||
                         (r_state == ST_AR) || (r_state == ST_R);
   // Fires on the TIMEOUT-th consecutive cycle without progress in a wait state.
   assign w_timeout    = w_wait_state && !w_hs && (r_wdog == WDOG_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk_i) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode: advance on handshakes, bail to DONE on watchdog expiry.
   always_comb begin
      // NOTE: default first so no path through this block leaves a variable unassigned (no latch).
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (start_i) w_state_nxt = ST_AW;
         ST_AW:   if (w_aw_hs) w_state_nxt = ST_W;
                  else if (w_timeout) w_state_nxt = ST_DONE;
         ST_W:    if (w_w_hs) begin
                     if (w_last) w_state_nxt = ST_B;
                  end else if (w_timeout) w_state_nxt = ST_DONE;
         ST_B:    if (w_b_hs) w_state_nxt = ST_AR;
                  else if (w_timeout) w_state_nxt = ST_DONE;
         ST_AR:   if (w_ar_hs) w_state_nxt = ST_R;
                  else if (w_timeout) w_state_nxt = ST_DONE;
         ST_R:    if (w_r_hs) begin
                     if (out_miso_i.rlast || w_last) w_state_nxt = ST_DONE;
                  end else if (w_timeout) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef AXI_TGEN_CHECK_EN
   logic [15:0] r_err_count;
   assign err_count_o = r_err_count;
   assign w_unused    = ^{out_miso_i.bid, out_miso_i.bresp, out_miso_i.rid, out_miso_i.rresp};
`else
   assign err_count_o = '0;
   assign w_unused    = ^{out_miso_i.bid, out_miso_i.bresp, out_miso_i.rid, out_miso_i.rresp,
                          out_miso_i.rdata};
`endif

   // Datapath: request latches, beat counter, watchdog and error tracking.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_base  <= '0;
         r_len   <= '0;
         r_burst <= '0;
         r_seed  <= '0;
         r_beat  <= '0;
         r_wdog  <= '0;
         r_error <= 1'b0;
`ifdef AXI_TGEN_CHECK_EN
         r_err_count <= '0;
`endif
      end else begin
         if ((r_state != w_state_nxt) || w_hs) r_wdog <= '0;
         else if (r_wdog != '1)                r_wdog <= r_wdog + 1'b1;

         unique case (r_state)
            ST_IDLE: if (start_i) begin
                        r_base  <= base_addr_i;
                        r_len   <= len_i;
                        r_burst <= burst_i;
                        r_seed  <= seed_i;
                        r_beat  <= '0;
                        r_error <= 1'b0;
`ifdef AXI_TGEN_CHECK_EN
                        r_err_count <= '0;
`endif
                     end
            ST_AW:   if (w_aw_hs) r_beat <= '0;
            ST_W:    if (w_w_hs)  r_beat <= r_beat + 8'd1;
            ST_AR:   if (w_ar_hs) r_beat <= '0;
            ST_R:    if (w_r_hs) begin
                        r_beat <= r_beat + 8'd1;
`ifdef AXI_TGEN_CHECK_EN
                        if (out_miso_i.rdata != w_data) begin
                           r_error <= 1'b1;
                           if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                        end
                        if (out_miso_i.rlast != w_last) r_error <= 1'b1;
`endif
                     end
            default: ;
         endcase

         if (w_timeout) r_error <= 1'b1;
      end
   end

   // AXI outputs decoded from state and registered request fields only.
   always_comb begin
      out_mosi_o = '0;
      unique case (r_state)
         ST_AW: begin
            out_mosi_o.awvalid = 1'b1;
            out_mosi_o.awid    = ID_W_WIDTH'(TXN_ID);
            out_mosi_o.awaddr  = r_base;
            out_mosi_o.awlen   = r_len;
            out_mosi_o.awsize  = AXI_SIZE;
            out_mosi_o.awburst = r_burst;
         end
         ST_W: begin
            out_mosi_o.wvalid = 1'b1;
            out_mosi_o.wdata  = w_data;
            out_mosi_o.wstrb  = '1;
            out_mosi_o.wlast  = w_last;
         end
         ST_B:  out_mosi_o.bready = 1'b1;
         ST_AR: begin
            out_mosi_o.arvalid = 1'b1;
            out_mosi_o.arid    = ID_R_WIDTH'(TXN_ID);
            out_mosi_o.araddr  = r_base;
            out_mosi_o.arlen   = r_len;
            out_mosi_o.arsize  = AXI_SIZE;
            out_mosi_o.arburst = r_burst;
         end
         ST_R:  out_mosi_o.rready = 1'b1;
         default: ;
      endcase
   end

   assign busy_o  = (r_state != ST_IDLE);
   assign done_o  = (r_state == ST_DONE);
   assign error_o = r_error;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen with a negedge-driven AXI slave model.
// Expected values for the read checker follow AXI_TGEN_CHECK_EN.
`timescale 1ns/1ps
module tb_axi_traffic_gen;
   import axi_tgen_pkg::*;

`ifdef AXI_TGEN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk_i       = 1'b0;
   logic        rst_n_i     = 1'b0;
   logic        start_i     = 1'b0;
   logic [3:0]  base_addr_i = '0;
   logic [7:0]  len_i       = '0;
   logic [1:0]  burst_i     = '0;
   logic [31:0] seed_i      = '0;
   axi_mosi_t   mosi;
   axi_miso_t   miso = '0;
   logic        busy_o, done_o, error_o;
   logic [15:0] err_count_o;

   int n_checks = 0;
   int n_errors = 0;

   // Slave model controls and observation log.
   bit          withhold_aw = 1'b0;
   bit          corrupt_b2  = 1'b0;
   bit          early_rlast = 1'b0;
   logic [31:0] wlog [0:255];
   int          w_cnt, wlast_bad, aw_cycles, done_cnt, aw_len, ar_len, r_cnt;

   axi_traffic_gen #(.TIMEOUT(16)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .burst_i     (burst_i),
      .seed_i      (seed_i),
      .out_mosi_o  (mosi),
      .out_miso_i  (miso),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .error_o     (error_o),
      .err_count_o (err_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Slave: responses change on the falling edge; a valid seen here with ready
   // set completes its handshake on the following rising edge.
   always @(negedge clk_i) begin
      miso.awready = !withhold_aw;
      miso.wready  = 1'b1;
      miso.arready = 1'b1;
      if (mosi.awvalid) begin
         aw_cycles++;
         if (miso.awready) aw_len = int'(mosi.awlen);
      end
      if (mosi.wvalid) begin
         wlog[8'(w_cnt)] = mosi.wdata;
         if (mosi.wlast != (w_cnt == aw_len)) wlast_bad++;
         w_cnt++;
      end
      miso.bvalid = mosi.bready;
      if (mosi.arvalid) begin
         ar_len = int'(mosi.arlen);
         r_cnt  = 0;
      end
      if (mosi.rready) begin
         miso.rvalid = 1'b1;
         miso.rdata  = wlog[8'(r_cnt)] ^ ((corrupt_b2 && r_cnt == 2) ? 32'h1 : 32'h0);
         miso.rlast  = early_rlast ? (r_cnt == 1) : (r_cnt == ar_len);
         r_cnt++;
      end else begin
         miso.rvalid = 1'b0;
         miso.rlast  = 1'b0;
         miso.rdata  = '0;
      end
      if (done_o) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      w_cnt = 0; wlast_bad = 0; aw_cycles = 0; done_cnt = 0;
      aw_len = 0; ar_len = 0; r_cnt = 0;
   endtask

   task automatic start_run(input logic [3:0] base, input logic [7:0] len, input logic [31:0] seed);
      @(negedge clk_i);
      clear_log();
      base_addr_i = base;
      len_i       = len;
      burst_i     = INCR;
      seed_i      = seed;
      start_i     = 1'b1;
      @(negedge clk_i);
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int i = 0;
      while (!done_o && i < budget) begin
         @(negedge clk_i);
         i++;
      end
      check({tag, " done seen"}, 32'(done_o), 32'd1);
      @(negedge clk_i);
      #1;
      check({tag, " done single"}, 32'(done_o), 32'd0);
      check({tag, " idle after"}, 32'(busy_o), 32'd0);
      check({tag, " done count"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      // Reset state.
      rst_n_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst mosi zero", 32'(mosi == '0), 32'd1);
      check("rst busy", 32'(busy_o), 32'd0);
      check("rst done", 32'(done_o), 32'd0);
      check("rst error", 32'(error_o), 32'd0);
      check("rst err_count", 32'(err_count_o), 32'd0);
      rst_n_i = 1'b1;

      // Basic burst: base 2, len 3, seed 0x100.
      start_run(4'h2, 8'd3, 32'h100);
      check("t1 busy", 32'(busy_o), 32'd1);
      check("t1 awvalid", 32'(mosi.awvalid), 32'd1);
      check("t1 awaddr", 32'(mosi.awaddr), 32'h2);
      check("t1 awlen", 32'(mosi.awlen), 32'd3);
      check("t1 awsize", 32'(mosi.awsize), 32'd2);
      check("t1 awburst", 32'(mosi.awburst), 32'd1);
      check("t1 awid", 32'(mosi.awid), 32'd0);
      wait_done("t1", 200);
      check("t1 w beats", 32'(w_cnt), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("t1 wdata%0d", i), wlog[i], 32'h100 + 32'(i));
      check("t1 wlast pos", 32'(wlast_bad), 32'd0);
      check("t1 r beats", 32'(r_cnt), 32'd4);
      check("t1 error", 32'(error_o), 32'd0);
      check("t1 err_count", 32'(err_count_o), 32'd0);

      // Single beat with wrapping seed.
      start_run(4'h0, 8'd0, 32'hFFFF_FFFF);
      wait_done("t2", 200);
      check("t2 w beats", 32'(w_cnt), 32'd1);
      check("t2 wdata", wlog[0], 32'hFFFF_FFFF);
      check("t2 wlast first", 32'(wlast_bad), 32'd0);
      check("t2 error", 32'(error_o), 32'd0);

      // Corrupt read beat 2.
      corrupt_b2 = 1'b1;
      start_run(4'h2, 8'd3, 32'h10);
      wait_done("t3", 200);
      corrupt_b2 = 1'b0;
      check("t3 err_count", 32'(err_count_o), CHK ? 32'd1 : 32'd0);
      check("t3 error", 32'(error_o), CHK ? 32'd1 : 32'd0);

      // Early RLAST on beat 1 of 4: burst ends there.
      early_rlast = 1'b1;
      start_run(4'h4, 8'd3, 32'h20);
      wait_done("t4", 200);
      early_rlast = 1'b0;
      check("t4 r beats", 32'(r_cnt), 32'd2);
      check("t4 error", 32'(error_o), CHK ? 32'd1 : 32'd0);
      check("t4 err_count", 32'(err_count_o), 32'd0);

      // AWREADY withheld: abort after 16 AW cycles, no W beat.
      withhold_aw = 1'b1;
      start_run(4'h1, 8'd2, 32'h55);
      wait_done("t5", 100);
      withhold_aw = 1'b0;
      check("t5 aw cycles", 32'(aw_cycles), 32'd16);
      check("t5 w beats", 32'(w_cnt), 32'd0);
      check("t5 error", 32'(error_o), 32'd1);
      check("t5 err_count", 32'(err_count_o), 32'd0);

      // Reset during W at beat 1, then a clean run.
      start_run(4'h2, 8'd3, 32'h200);
      begin
         int i = 0;
         while (!(mosi.wvalid && mosi.wdata == 32'h201) && i < 50) begin
            @(negedge clk_i);
            i++;
         end
      end
      check("t6 at beat1", 32'(mosi.wvalid && mosi.wdata == 32'h201), 32'd1);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check("t6 rst wvalid", 32'(mosi.wvalid), 32'd0);
      check("t6 rst busy", 32'(busy_o), 32'd0);
      check("t6 rst mosi zero", 32'(mosi == '0), 32'd1);
      rst_n_i = 1'b1;
      start_run(4'h2, 8'd3, 32'h300);
      wait_done("t6", 200);
      check("t6 w beats", 32'(w_cnt), 32'd4);
      check("t6 wdata3", wlog[3], 32'h303);
      check("t6 wlast pos", 32'(wlast_bad), 32'd0);
      check("t6 error", 32'(error_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
